// File: rtl/circle_bitmap_reader_if.sv
// circle_bitmap_reader_if
//   Bundles the two handshake groups of the circle bitmap reader:
//   - Avalon-MM read master: m_read, m_address, m_waitrequest,
//     m_readdata, m_readdatavalid (pipelined, in-order responses).
//   - Output word stream: out_valid, out_ready, out_data, out_last.
//   Modports:
//   - master : the reader side (drives requests and the stream).
//   - slave  : the environment side (memory slave and stream consumer).
//
// Handshake semantics (both groups):
//   Avalon: a read is accepted on a cycle with m_read=1 and m_waitrequest=0;
//   while m_waitrequest=1 the master holds m_read and m_address. Every
//   accepted read gets exactly one m_readdatavalid strobe, in issue order.
//   Stream: a word transfers on a cycle with out_valid=1 and out_ready=1;
//   once out_valid is high the word and out_last stay stable until taken.
interface circle_bitmap_reader_if #(
  parameter int DATAW = 18
);
  logic             m_read;
  logic [DATAW-1:0] m_address;
  logic             m_waitrequest;
  logic [31:0]      m_readdata;
  logic             m_readdatavalid;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;

  modport master (
    output m_read, m_address,
    input  m_waitrequest, m_readdata, m_readdatavalid,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  m_read, m_address,
    output m_waitrequest, m_readdata, m_readdatavalid,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/circle_bitmap_reader.sv
// circle_bitmap_reader
//   Reads the 1-bit circle bitmap back from the plotter slave with
//   pipelined single-pixel Avalon reads, extracts each pixel bit and packs
//   pixels LSB-first into 32-bit words delivered on a valid/ready stream.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   start            one-cycle pulse, begins a scan (ignored while busy)
//   base_addr        first pixel address, sampled on accepted start
//   pix_count        number of pixels, sampled on accepted start
//   busy, done       scan in progress / one-cycle completion pulse
//   state_dbg        current FSM state
//   outstanding_dbg  reads accepted but not yet answered
//   fifo_count_dbg   words held in the output FIFO
//   set_count        (CIRCLE_READER_POPCOUNT_EN only) number of set pixels
//   bus              circle_bitmap_reader_if.master (Avalon + stream)
//
// Optional feature macro: CIRCLE_READER_POPCOUNT_EN adds set_count.
module circle_bitmap_reader #(
  parameter int DATAW       = 18,
  parameter int MAX_PENDING = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [DATAW-1:0]                     base_addr,
  input  logic [DATAW:0]                       pix_count,
  output logic                                 busy,
  output logic                                 done,
`ifdef CIRCLE_READER_POPCOUNT_EN
  output logic [DATAW:0]                       set_count,
`endif
  output logic [2:0]                           state_dbg,
  output logic [$clog2(MAX_PENDING+1)-1:0]     outstanding_dbg,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count_dbg,
  circle_bitmap_reader_if.master               bus
);
  localparam int OW  = $clog2(MAX_PENDING + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FCW = PW + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, FLUSH, DRAIN} state_t;

  state_t            state_q;
  logic [DATAW-1:0]  addr_q;
  logic [DATAW:0]    issue_left_q;
  logic [DATAW:0]    rsp_left_q;
  logic [2:0]        rsp_addr_q;     // only the bit-select part is needed
  logic [4:0]        pix_idx_q;
  logic [31:0]       pack_q;
  logic [OW-1:0]     outst_q;
  logic              stall_q;
  logic              done_q;
  logic              last_sent_q;
  logic [31:0]       fifo_data_q [FIFO_DEPTH];
  logic              fifo_last_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [FCW-1:0]    fcount_q;
`ifdef CIRCLE_READER_POPCOUNT_EN
  logic [DATAW:0]    set_count_q;
`endif

  logic        fifo_empty;
  logic        m_read_c;
  logic        accept;
  logic        rsp;
  logic        rsp_bit;
  logic [31:0] packed_word;
  logic        rsp_push;
  logic        flush_push;
  logic        push;
  logic [31:0] push_data;
  logic        push_last;
  logic        pop;

  assign fifo_empty  = (fcount_q == '0);
  // Once a request is presented while stalled it must stay up even if the
  // throttle conditions change; stall_q remembers that obligation.
  assign m_read_c    = (state_q == ISSUE) &&
                       (stall_q || ((outst_q < OW'(MAX_PENDING)) &&
                                    (fcount_q < FCW'(FIFO_DEPTH - 1))));
  assign accept      = m_read_c && !bus.m_waitrequest;
  // Stray strobes with nothing in flight are dropped.
  assign rsp         = bus.m_readdatavalid && (outst_q != '0);
  assign rsp_bit     = bus.m_readdata[rsp_addr_q];
  assign packed_word = pack_q | (32'(rsp_bit) << pix_idx_q);
  assign rsp_push    = rsp && (pix_idx_q == 5'd31);
  assign flush_push  = (state_q == FLUSH) && (pix_idx_q != 5'd0);
  assign push        = rsp_push || flush_push;
  assign push_data   = rsp_push ? packed_word : pack_q;
  // A full final word is pushed by its last response, so it carries last.
  assign push_last   = rsp_push ? (rsp_left_q == (DATAW+1)'(1)) : 1'b1;
  assign pop         = !fifo_empty && bus.out_ready;

  assign bus.m_read    = m_read_c;
  assign bus.m_address = addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? 32'd0 : fifo_data_q[rd_ptr_q];
  assign bus.out_last  = fifo_empty ? 1'b0 : fifo_last_q[rd_ptr_q];
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign state_dbg       = state_q;
  assign outstanding_dbg = outst_q;
  assign fifo_count_dbg  = fcount_q;
`ifdef CIRCLE_READER_POPCOUNT_EN
  assign set_count       = set_count_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      rsp_left_q   <= '0;
      rsp_addr_q   <= '0;
      pix_idx_q    <= '0;
      pack_q       <= '0;
      outst_q      <= '0;
      stall_q      <= 1'b0;
      done_q       <= 1'b0;
      last_sent_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcount_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
`ifdef CIRCLE_READER_POPCOUNT_EN
      set_count_q  <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      stall_q <= m_read_c && bus.m_waitrequest;

      if (accept) begin
        addr_q       <= addr_q + DATAW'(1);
        issue_left_q <= issue_left_q - (DATAW+1)'(1);
      end

      case ({accept, rsp})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: outst_q <= outst_q;
      endcase

      if (rsp) begin
        rsp_addr_q <= rsp_addr_q + 3'd1;
        rsp_left_q <= rsp_left_q - (DATAW+1)'(1);
        pix_idx_q  <= pix_idx_q + 5'd1;
        pack_q     <= rsp_push ? 32'd0 : packed_word;
`ifdef CIRCLE_READER_POPCOUNT_EN
        if (rsp_bit) set_count_q <= set_count_q + (DATAW+1)'(1);
`endif
      end

      if (flush_push) begin
        pack_q    <= '0;
        pix_idx_q <= '0;
      end

      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_last_q[wr_ptr_q] <= push_last;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        if (fifo_last_q[rd_ptr_q]) last_sent_q <= 1'b1;
      end
      case ({push, pop})
        2'b10:   fcount_q <= fcount_q + FCW'(1);
        2'b01:   fcount_q <= fcount_q - FCW'(1);
        default: fcount_q <= fcount_q;
      endcase

      case (state_q)
        IDLE: begin
          if (start) begin
`ifdef CIRCLE_READER_POPCOUNT_EN
            set_count_q <= '0;
`endif
            if (pix_count == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q      <= ISSUE;
              addr_q       <= base_addr;
              rsp_addr_q   <= base_addr[2:0];
              issue_left_q <= pix_count;
              rsp_left_q   <= pix_count;
              pix_idx_q    <= '0;
              pack_q       <= '0;
              last_sent_q  <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (accept && (issue_left_q == (DATAW+1)'(1))) state_q <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (rsp_left_q == '0) state_q <= FLUSH;
        end
        FLUSH: begin
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty && last_sent_q) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
